// File: rtl/mbist_mux_rep.sv
// mbist_mux_rep: MBIST / functional mux for one 1R1W SRAM macro.
// A request/acknowledge mode FSM drains the memory before handing it to
// BIST, so BIST and functional traffic never mix. A small repair CAM
// remaps failing rows to spare rows; it is scannable for save/restore.
module mbist_mux_rep #(
  parameter int BIST_ADDR_WD = 9,
  parameter int BIST_DATA_WD = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END = 9'h1F8,
  parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1FC,
  parameter int BIST_REPAIR_DEPTH = 4,
  parameter int BIST_DRAIN_CYC = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        bist_req,
  output logic                        bist_ack,
  input  logic [BIST_ADDR_WD-1:0]     bist_addr,
  input  logic [BIST_DATA_WD-1:0]     bist_wdata,
  input  logic                        bist_wr,
  input  logic                        bist_rd,
  input  logic                        bist_error,
  input  logic [BIST_ADDR_WD-1:0]     bist_error_addr,
  output logic                        bist_correct,
  output logic                        bist_repair_fail,
  input  logic                        bist_sdi,
  input  logic                        bist_shift,
  output logic                        bist_sdo,
  output logic                        func_ready,
  input  logic                        func_cen_a,
  input  logic [BIST_ADDR_WD-1:0]     func_addr_a,
  output logic [BIST_DATA_WD-1:0]     func_dout_a,
  input  logic                        func_cen_b,
  input  logic                        func_web_b,
  input  logic [BIST_DATA_WD/8-1:0]   func_mask_b,
  input  logic [BIST_ADDR_WD-1:0]     func_addr_b,
  input  logic [BIST_DATA_WD-1:0]     func_din_b,
  output logic                        mem_cen_a,
  output logic [BIST_ADDR_WD-1:0]     mem_addr_a,
  input  logic [BIST_DATA_WD-1:0]     mem_dout_a,
  output logic                        mem_cen_b,
  output logic                        mem_web_b,
  output logic [BIST_DATA_WD/8-1:0]   mem_mask_b,
  output logic [BIST_ADDR_WD-1:0]     mem_addr_b,
  output logic [BIST_DATA_WD-1:0]     mem_din_b
);

  localparam int ENT_WD  = BIST_ADDR_WD + 1;
  localparam int CHAIN_L = BIST_REPAIR_DEPTH * ENT_WD;

  typedef enum logic [1:0] {ST_FUNC, ST_DRAIN, ST_BIST, ST_EXIT} mode_t;

  mode_t       state, state_nxt;
  logic [3:0]  drain_cnt, drain_cnt_nxt;

  // CAM storage doubles as the scan chain: entry i occupies
  // chain[i*ENT_WD +: ENT_WD] as {valid, addr}, entry D-1 at the top.
  logic [CHAIN_L-1:0]                           chain;
  logic [BIST_REPAIR_DEPTH-1:0]                 ent_v;
  logic [BIST_REPAIR_DEPTH-1:0][BIST_ADDR_WD-1:0] ent_a;

  logic [BIST_REPAIR_DEPTH-1:0] wr_sel;
  logic                         cam_hit, cam_full, err_oor, err_take;

  logic                    m_cen_a, m_cen_b, m_web_b;
  logic [BIST_ADDR_WD-1:0] m_addr_a, m_addr_b;

  // Lowest-index matching valid entry selects the spare row.
  function automatic logic [BIST_ADDR_WD-1:0] remap(
    input logic [BIST_REPAIR_DEPTH-1:0]                   v,
    input logic [BIST_REPAIR_DEPTH-1:0][BIST_ADDR_WD-1:0] a,
    input logic [BIST_ADDR_WD-1:0]                        addr
  );
    logic [BIST_ADDR_WD-1:0] r;
    r = addr;
    for (int i = BIST_REPAIR_DEPTH - 1; i >= 0; i--) begin
      if (v[i] && (a[i] == addr)) r = BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(i);
    end
    return r;
  endfunction

  // Mode state register and drain counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FUNC;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Mode next-state: drain before granting, one idle cycle on the way out.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    unique case (state)
      ST_FUNC: begin
        if (bist_req) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (!bist_req) state_nxt = ST_EXIT;
        else if (drain_cnt == 4'(BIST_DRAIN_CYC - 1)) state_nxt = ST_BIST;
        else drain_cnt_nxt = drain_cnt + 4'd1;
      end
      ST_BIST: begin
        if (!bist_req) state_nxt = ST_EXIT;
      end
      ST_EXIT: state_nxt = ST_FUNC;
      default: state_nxt = ST_FUNC;
    endcase
  end

  // Unpack the chain into per-entry fields and find the capture target.
  always_comb begin
    logic found;
    ent_v    = '0;
    ent_a    = '0;
    wr_sel   = '0;
    cam_hit  = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < BIST_REPAIR_DEPTH; i++) begin
      ent_v[i] = chain[i*ENT_WD + BIST_ADDR_WD];
      ent_a[i] = chain[i*ENT_WD +: BIST_ADDR_WD];
      if (ent_v[i] && (ent_a[i] == bist_error_addr)) cam_hit = 1'b1;
      if (!ent_v[i] && !found) begin
        wr_sel[i] = 1'b1;
        found     = 1'b1;
      end
    end
    cam_full = !found;
    // One unsigned compare covers both ends of the repairable window.
    err_oor  = (bist_error_addr - BIST_ADDR_START) > (BIST_ADDR_END - BIST_ADDR_START);
    err_take = bist_error && (state == ST_BIST) && !bist_shift;
  end

  // CAM / scan chain: shifting wins over error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (bist_shift) begin
      chain <= {chain[CHAIN_L-2:0], bist_sdi};
    end else if (err_take && !err_oor && !cam_hit && !cam_full) begin
      for (int i = 0; i < BIST_REPAIR_DEPTH; i++) begin
        if (wr_sel[i]) chain[i*ENT_WD +: ENT_WD] <= {1'b1, bist_error_addr};
      end
    end
  end

  // Sticky repair failure: out-of-range address or no free entry left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bist_repair_fail <= 1'b0;
    end else if (err_take && (err_oor || (!cam_hit && cam_full))) begin
      bist_repair_fail <= 1'b1;
    end
  end

  // Memory mux: functional in FUNC, BIST in BIST, fully idle otherwise.
  always_comb begin
    func_ready = 1'b0;
    bist_ack   = 1'b0;
    m_cen_a    = 1'b1;
    m_addr_a   = '0;
    m_cen_b    = 1'b1;
    m_web_b    = 1'b1;
    m_addr_b   = '0;
    mem_mask_b = '0;
    mem_din_b  = '0;
    unique case (state)
      ST_FUNC: begin
        func_ready = 1'b1;
        m_cen_a    = func_cen_a;
        m_addr_a   = func_addr_a;
        m_cen_b    = func_cen_b;
        m_web_b    = func_web_b;
        m_addr_b   = func_addr_b;
        mem_mask_b = func_mask_b;
        mem_din_b  = func_din_b;
      end
      ST_BIST: begin
        bist_ack   = 1'b1;
        m_cen_a    = !bist_rd;
        m_addr_a   = bist_addr;
        m_cen_b    = !bist_wr;
        m_web_b    = !bist_wr;
        m_addr_b   = bist_addr;
        mem_mask_b = '1;
        mem_din_b  = bist_wdata;
      end
      default: ;
    endcase
  end

  assign mem_cen_a    = m_cen_a;
  assign mem_cen_b    = m_cen_b;
  assign mem_web_b    = m_web_b;
  assign mem_addr_a   = remap(ent_v, ent_a, m_addr_a);
  assign mem_addr_b   = remap(ent_v, ent_a, m_addr_b);
  assign func_dout_a  = mem_dout_a;
  assign bist_correct = (|ent_v) && !bist_repair_fail;
  assign bist_sdo     = chain[CHAIN_L-1];

endmodule

// File: tb/tb_mbist_mux_rep.sv
// Testbench for mbist_mux_rep: table-driven functional mux vectors,
// hand-written mode/repair/scan/reset sequences, and randomized repair
// traffic checked against a queue-based model of the repair CAM.
module tb_mbist_mux_rep;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int DEPTH = 4;
  localparam int DRAIN = 2;
  localparam int L = DEPTH * (AW + 1);
  localparam logic [AW-1:0] END_A = 9'h1F8;
  localparam logic [AW-1:0] SPARE = 9'h1FC;

  logic clk, rst_n;
  logic bist_req, bist_ack, bist_wr, bist_rd, bist_error;
  logic [AW-1:0] bist_addr, bist_error_addr;
  logic [DW-1:0] bist_wdata;
  logic bist_correct, bist_repair_fail, bist_sdi, bist_shift, bist_sdo;
  logic func_ready, func_cen_a, func_cen_b, func_web_b;
  logic [AW-1:0] func_addr_a, func_addr_b;
  logic [DW-1:0] func_dout_a, func_din_b;
  logic [MW-1:0] func_mask_b;
  logic mem_cen_a, mem_cen_b, mem_web_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_dout_a, mem_din_b;
  logic [MW-1:0] mem_mask_b;

  int n_tests = 0;
  int n_fail = 0;

  mbist_mux_rep #(
    .BIST_ADDR_WD(AW), .BIST_DATA_WD(DW), .BIST_ADDR_START(9'h000),
    .BIST_ADDR_END(END_A), .BIST_REPAIR_ADDR_START(SPARE),
    .BIST_REPAIR_DEPTH(DEPTH), .BIST_DRAIN_CYC(DRAIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bist_req(bist_req), .bist_ack(bist_ack),
    .bist_addr(bist_addr), .bist_wdata(bist_wdata), .bist_wr(bist_wr),
    .bist_rd(bist_rd), .bist_error(bist_error), .bist_error_addr(bist_error_addr),
    .bist_correct(bist_correct), .bist_repair_fail(bist_repair_fail),
    .bist_sdi(bist_sdi), .bist_shift(bist_shift), .bist_sdo(bist_sdo),
    .func_ready(func_ready), .func_cen_a(func_cen_a), .func_addr_a(func_addr_a),
    .func_dout_a(func_dout_a), .func_cen_b(func_cen_b), .func_web_b(func_web_b),
    .func_mask_b(func_mask_b), .func_addr_b(func_addr_b), .func_din_b(func_din_b),
    .mem_cen_a(mem_cen_a), .mem_addr_a(mem_addr_a), .mem_dout_a(mem_dout_a),
    .mem_cen_b(mem_cen_b), .mem_web_b(mem_web_b), .mem_mask_b(mem_mask_b),
    .mem_addr_b(mem_addr_b), .mem_din_b(mem_din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          cen_a;
    logic [AW-1:0] addr_a;
    logic          cen_b;
    logic          web_b;
    logic [MW-1:0] mask;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din;
    logic [DW-1:0] mdout;
    logic [AW-1:0] e_addr_a;
    logic [AW-1:0] e_addr_b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bist_wr = 0; bist_rd = 0; bist_error = 0; bist_error_addr = '0;
    bist_addr = '0; bist_wdata = '0; bist_sdi = 0; bist_shift = 0;
    func_cen_a = 1; func_addr_a = '0; func_cen_b = 1; func_web_b = 1;
    func_mask_b = '0; func_addr_b = '0; func_din_b = '0; mem_dout_a = '0;
  endtask

  task automatic enter_bist();
    bist_req = 1;
    repeat (DRAIN + 1) tick();
    chk("enter_ack", bist_ack, 1'b1);
  endtask

  task automatic exit_bist();
    bist_req = 0;
    repeat (2) tick();
    chk("exit_ready", func_ready, 1'b1);
  endtask

  task automatic pulse_error(input logic [AW-1:0] a);
    bist_error = 1; bist_error_addr = a;
    tick();
    bist_error = 0;
  endtask

  task automatic bist_read(input string name, input logic [AW-1:0] a, input logic [AW-1:0] exp);
    bist_rd = 1; bist_addr = a;
    settle();
    chk(name, mem_addr_a, exp);
    bist_rd = 0;
  endtask

  // Reference model of the repair CAM: repaired addresses in allocation order.
  logic [AW-1:0] model_q[$];
  logic          model_fail;

  function automatic int model_find(input logic [AW-1:0] a);
    for (int i = 0; i < model_q.size(); i++) if (model_q[i] == a) return i;
    return -1;
  endfunction

  logic [L-1:0] exp_chain;
  logic [L-1:0] got_chain;
  logic [AW-1:0] pool[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; bist_req = 0;
    idle_inputs();

    // ---- reset values
    repeat (3) tick();
    chk("rst_ack", bist_ack, 1'b0);
    chk("rst_ready", func_ready, 1'b1);
    chk("rst_correct", bist_correct, 1'b0);
    chk("rst_fail", bist_repair_fail, 1'b0);
    chk("rst_sdo", bist_sdo, 1'b0);
    rst_n = 1;
    tick();

    // ---- mode handshake with functional strobes held active throughout
    func_cen_a = 0; func_cen_b = 0; func_web_b = 0; func_addr_a = 9'h011;
    bist_req = 1;
    settle();
    chk("c0_ready", func_ready, 1'b1);
    chk("c0_cen_a", mem_cen_a, 1'b0);
    tick();
    for (int c = 1; c <= DRAIN; c++) begin
      bist_rd = 1; bist_wr = 1;
      settle();
      chk("drain_ready", func_ready, 1'b0);
      chk("drain_cen_a", mem_cen_a, 1'b1);
      chk("drain_cen_b", mem_cen_b, 1'b1);
      chk("drain_web_b", mem_web_b, 1'b1);
      chk("drain_ack", bist_ack, 1'b0);
      tick();
    end
    chk("bist_ack_cyc3", bist_ack, 1'b1);
    chk("bist_cen_a", mem_cen_a, 1'b0);
    bist_req = 0; bist_rd = 0; bist_wr = 0;
    tick();
    chk("exit_ack", bist_ack, 1'b0);
    chk("exit_ready", func_ready, 1'b0);
    chk("exit_cen_a", mem_cen_a, 1'b1);
    tick();
    chk("back_ready", func_ready, 1'b1);
    chk("back_cen_a", mem_cen_a, 1'b0);
    idle_inputs();

    // ---- repair capture, duplicates ignored
    enter_bist();
    pulse_error(9'h020);
    pulse_error(9'h020);
    pulse_error(9'h030);
    settle();
    chk("two_correct", bist_correct, 1'b1);
    chk("two_fail", bist_repair_fail, 1'b0);
    bist_read("rd_030", 9'h030, 9'h1FD);
    bist_read("rd_020", 9'h020, 9'h1FC);
    bist_read("rd_040", 9'h040, 9'h040);
    bist_wr = 1; bist_addr = 9'h030; bist_wdata = 32'h1234_5678;
    settle();
    chk("wr_addr_b", mem_addr_b, 9'h1FD);
    chk("wr_cen_b", mem_cen_b, 1'b0);
    chk("wr_web_b", mem_web_b, 1'b0);
    chk("wr_mask", mem_mask_b, 4'hF);
    chk("wr_din", mem_din_b, 32'h1234_5678);
    bist_wr = 0;

    // ---- scan out with sdi=0, then restore
    exp_chain = {10'h000, 10'h000, 1'b1, 9'h030, 1'b1, 9'h020};
    got_chain = '0;
    bist_shift = 1; bist_sdi = 0;
    for (int k = 0; k < L; k++) begin
      got_chain[L-1-k] = bist_sdo;
      tick();
    end
    bist_shift = 0;
    chk("scan_out", got_chain, exp_chain);
    settle();
    chk("scan_empty_correct", bist_correct, 1'b0);
    bist_read("scan_empty_rd", 9'h030, 9'h030);
    bist_shift = 1;
    for (int k = 0; k < L; k++) begin
      bist_sdi = exp_chain[L-1-k];
      tick();
    end
    bist_shift = 0; bist_sdi = 0;
    bist_read("restore_rd_030", 9'h030, 9'h1FD);
    bist_read("restore_rd_020", 9'h020, 9'h1FC);
    chk("restore_correct", bist_correct, 1'b1);

    // ---- functional table with two repaired rows, BIST strobes ignored
    exit_bist();
    vecs[0] = '{1, 9'h010, 0, 0, 4'hF, 9'h010, 32'hA5A5A5A5, 32'h0, 9'h010, 9'h010};
    vecs[1] = '{0, 9'h010, 1, 1, 4'h0, 9'h000, 32'h0, 32'hA5A5A5A5, 9'h010, 9'h000};
    vecs[2] = '{0, 9'h020, 0, 0, 4'h5, 9'h030, 32'hCAFE0001, 32'h11, 9'h1FC, 9'h1FD};
    vecs[3] = '{0, 9'h030, 0, 0, 4'h3, 9'h020, 32'hCAFE0002, 32'h22, 9'h1FD, 9'h1FC};
    vecs[4] = '{0, 9'h1F8, 0, 0, 4'hA, 9'h040, 32'hDEADBEEF, 32'h33, 9'h1F8, 9'h040};
    vecs[5] = '{1, 9'h1FF, 0, 1, 4'h8, 9'h031, 32'h0BADF00D, 32'h44, 9'h1FF, 9'h031};
    bist_wr = 1; bist_rd = 1; bist_addr = 9'h1AB; bist_wdata = 32'hFFFF0000;
    for (int i = 0; i < 6; i++) begin
      func_cen_a = vecs[i].cen_a; func_addr_a = vecs[i].addr_a;
      func_cen_b = vecs[i].cen_b; func_web_b = vecs[i].web_b;
      func_mask_b = vecs[i].mask; func_addr_b = vecs[i].addr_b;
      func_din_b = vecs[i].din; mem_dout_a = vecs[i].mdout;
      settle();
      chk($sformatf("v%0d_cen_a", i), mem_cen_a, vecs[i].cen_a);
      chk($sformatf("v%0d_addr_a", i), mem_addr_a, vecs[i].e_addr_a);
      chk($sformatf("v%0d_cen_b", i), mem_cen_b, vecs[i].cen_b);
      chk($sformatf("v%0d_web_b", i), mem_web_b, vecs[i].web_b);
      chk($sformatf("v%0d_mask", i), mem_mask_b, vecs[i].mask);
      chk($sformatf("v%0d_addr_b", i), mem_addr_b, vecs[i].e_addr_b);
      chk($sformatf("v%0d_din", i), mem_din_b, vecs[i].din);
      chk($sformatf("v%0d_dout", i), func_dout_a, vecs[i].mdout);
      chk($sformatf("v%0d_ack", i), bist_ack, 1'b0);
      tick();
    end
    idle_inputs();

    // ---- same-cycle error/access, then fill and overflow
    enter_bist();
    bist_rd = 1; bist_addr = 9'h050; bist_error = 1; bist_error_addr = 9'h050;
    settle();
    chk("same_cycle_no_remap", mem_addr_a, 9'h050);
    tick();
    bist_error = 0;
    settle();
    chk("next_cycle_remap", mem_addr_a, 9'h1FE);
    bist_rd = 0;
    pulse_error(9'h060);
    bist_read("rd_060", 9'h060, 9'h1FF);
    chk("full_correct", bist_correct, 1'b1);
    pulse_error(9'h020);
    settle();
    chk("full_dup_fail", bist_repair_fail, 1'b0);
    pulse_error(9'h070);
    settle();
    chk("overflow_fail", bist_repair_fail, 1'b1);
    chk("overflow_correct", bist_correct, 1'b0);
    bist_read("overflow_rd_070", 9'h070, 9'h070);

    // ---- asynchronous reset clears everything
    bist_req = 0;
    #2 rst_n = 0;
    func_cen_a = 0; func_addr_a = 9'h020;
    settle();
    chk("arst_fail", bist_repair_fail, 1'b0);
    chk("arst_correct", bist_correct, 1'b0);
    chk("arst_ready", func_ready, 1'b1);
    chk("arst_addr", mem_addr_a, 9'h020);
    tick();
    rst_n = 1;
    idle_inputs();
    tick();

    // ---- out-of-range error alone, then reset mid-DRAIN
    enter_bist();
    pulse_error(9'h1F9);
    settle();
    chk("oor_fail", bist_repair_fail, 1'b1);
    chk("oor_correct", bist_correct, 1'b0);
    bist_read("oor_rd", 9'h1F9, 9'h1F9);
    pulse_error(9'h1F8);
    bist_read("end_rd", 9'h1F8, 9'h1FC);
    exit_bist();
    func_cen_a = 0; func_addr_a = 9'h1F8;
    settle();
    chk("func_remap", mem_addr_a, 9'h1FC);
    bist_req = 1;
    tick();
    chk("middrain_ready", func_ready, 1'b0);
    chk("middrain_cen", mem_cen_a, 1'b1);
    #2 rst_n = 0;
    settle();
    chk("middrain_rst_ready", func_ready, 1'b1);
    chk("middrain_rst_cen", mem_cen_a, 1'b0);
    chk("middrain_rst_addr", mem_addr_a, 9'h1F8);
    chk("middrain_rst_fail", bist_repair_fail, 1'b0);
    bist_req = 0;
    tick();
    rst_n = 1;
    idle_inputs();
    tick();

    // ---- randomized repair traffic against the queue model
    pool = '{9'h000, 9'h001, 9'h020, 9'h030, 9'h0FF, 9'h100,
             9'h1F8, 9'h1F9, 9'h1FC, 9'h1FF, 9'h055, 9'h0AA};
    for (int r = 0; r < 4; r++) begin
      rst_n = 0;
      tick();
      rst_n = 1;
      model_q.delete();
      model_fail = 0;
      enter_bist();
      for (int c = 0; c < 60; c++) begin
        int idx;
        logic [AW-1:0] exp_a;
        bist_error = ($urandom_range(0, 2) == 0);
        bist_error_addr = pool[$urandom_range(0, 11)];
        bist_rd = $urandom_range(0, 1);
        bist_addr = pool[$urandom_range(0, 11)];
        settle();
        idx = model_find(bist_addr);
        exp_a = (idx >= 0) ? SPARE + AW'(idx) : bist_addr;
        chk("rnd_addr_a", mem_addr_a, exp_a);
        chk("rnd_addr_b", mem_addr_b, exp_a);
        chk("rnd_cen_a", mem_cen_a, !bist_rd);
        chk("rnd_fail", bist_repair_fail, model_fail);
        chk("rnd_correct", bist_correct, (model_q.size() > 0) && !model_fail);
        if (bist_error) begin
          if (bist_error_addr > END_A) model_fail = 1;
          else if (model_find(bist_error_addr) >= 0) ;
          else if (model_q.size() == DEPTH) model_fail = 1;
          else model_q.push_back(bist_error_addr);
        end
        tick();
      end
      idle_inputs();
      bist_req = 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mbist_mux_rep.md
# mbist_mux_rep

Parametrised next-generation MBIST/functional memory mux for one 1R1W SRAM macro, on a single clock. Adds a request/acknowledge mode-switch FSM with drain cycles, so the memory never sees mixed BIST and functional traffic. Adds a multi-entry repair CAM (BIST_REPAIR_DEPTH spare rows) with scan save/restore. It sits between the MBIST controller, the functional master and the SRAM wrapper.

## Interface
Parameters:
- BIST_ADDR_WD, 9: memory address width.
- BIST_DATA_WD, 32: data width; must be a multiple of 8.
- BIST_ADDR_START, 9'h000: first testable address.
- BIST_ADDR_END, 9'h1F8: last testable (repairable) address.
- BIST_REPAIR_ADDR_START, 9'h1FC: physical address of spare row 0; spare i maps to BIST_REPAIR_ADDR_START+i.
- BIST_REPAIR_DEPTH, 4: number of repair entries, 1..8.
- BIST_DRAIN_CYC, 2: cycles both chip-enables are forced inactive on entry to BIST mode, 1..15.

Ports:
- clk, in, 1: single clock for memory, BIST and functional sides.
- rst_n, in, 1: asynchronous active-low reset.
- bist_req, in, 1: BIST mode request, level.
- bist_ack, out, 1: BIST mode granted.
- bist_addr, in, BIST_ADDR_WD: BIST address.
- bist_wdata, in, BIST_DATA_WD: BIST write data.
- bist_wr / bist_rd, in, 1 each: BIST write / read strobes.
- bist_error, in, 1: error pulse, one cycle.
- bist_error_addr, in, BIST_ADDR_WD: logical address that failed.
- bist_correct, out, 1: at least one repair made and no repair failure.
- bist_repair_fail, out, 1: sticky repair failure.
- bist_sdi, in, 1: scan serial input.
- bist_shift, in, 1: scan shift enable.
- bist_sdo, out, 1: scan serial output.
- func_ready, out, 1: functional accesses accepted.
- func_cen_a, in, 1: functional read port chip enable, active-low.
- func_addr_a, in, BIST_ADDR_WD: functional read address.
- func_dout_a, out, BIST_DATA_WD: read data returned to both sides.
- func_cen_b, in, 1: functional write port chip enable, active-low.
- func_web_b, in, 1: functional write enable, active-low.
- func_mask_b, in, BIST_DATA_WD/8: functional byte mask.
- func_addr_b, in, BIST_ADDR_WD: functional write address.
- func_din_b, in, BIST_DATA_WD: functional write data.
- mem_cen_a, mem_addr_a, out: SRAM read port.
- mem_dout_a, in, BIST_DATA_WD: SRAM read data.
- mem_cen_b, mem_web_b, mem_mask_b, mem_addr_b, mem_din_b, out: SRAM write port.

## Operation
Mode FSM states: FUNC, DRAIN, BIST, EXIT. Reset state is FUNC.
- FUNC: functional inputs drive the memory and func_ready=1. bist_req=1 → DRAIN.
- DRAIN: runs BIST_DRAIN_CYC cycles with mem_cen_a=mem_cen_b=mem_web_b=1 and func_ready=0, then → BIST. If bist_req drops during DRAIN → EXIT.
- BIST: bist_ack=1; the memory is driven as mem_cen_a=!bist_rd, mem_cen_b=mem_web_b=!bist_wr, mask all-ones, din=bist_wdata, both addresses from bist_addr. bist_req=0 → EXIT.
- EXIT: one cycle with both chip-enables inactive, then → FUNC.
- bist_wr and bist_rd are ignored outside BIST. Functional strobes are ignored, not queued, while func_ready=0.
- func_dout_a = mem_dout_a, passed through in every state.

Repair CAM: BIST_REPAIR_DEPTH entries, each {valid, addr}.
- Address remap is combinational on both ports. If the muxed address matches a valid entry i, the output address is BIST_REPAIR_ADDR_START+i; otherwise the address passes through. If several entries match, the lowest index wins.
- bist_error is sampled in BIST state only. Address ≤ BIST_ADDR_END and not already valid in the CAM → written to the lowest free entry.
- Address already present → no change.
- CAM full, or address > BIST_ADDR_END → bist_repair_fail is set.
- bist_correct = (any valid) & !bist_repair_fail.

Scan:
- Chain length L = BIST_REPAIR_DEPTH*(BIST_ADDR_WD+1), ordered {v[D-1],a[D-1],…,v[0],a[0]}, MSB first.
- bist_shift=1 → chain <= {chain[L-2:0], bist_sdi}; bist_sdo = chain[L-1].
- Shifting has priority over error capture. bist_repair_fail is not part of the chain.

Reset: asserting rst_n low at any time, including mid-DRAIN or mid-shift, clears the CAM and bist_repair_fail and returns the FSM to FUNC.

## Timing
- Reset values: bist_ack=0, func_ready=1, bist_correct=0, bist_repair_fail=0, bist_sdo=0. CAM is all-invalid.
- Mem outputs are combinational from the current state, the mux inputs and the CAM; there is no added latency.
- bist_ack rises BIST_DRAIN_CYC+1 cycles after bist_req is first sampled high. func_ready falls 1 cycle after bist_req is sampled high.
- After bist_req falls: bist_ack falls 1 cycle later, and func_ready rises 2 cycles later.
- A CAM write from bist_error at edge n remaps accesses from cycle n+1.
- A simultaneous error and access to the same address in cycle n is not remapped in cycle n.

## Test plan
- Reset, then functional write of 0xA5A5A5A5 @0x010 and read @0x010 → mem_addr=0x010, func_dout_a returns data, bist_ack=0.
- Pulse bist_req with BIST_DRAIN_CYC=2 → func_ready=0 from cycle 1, both chip-enables high for cycles 1-2, bist_ack=1 at cycle 3. Drop bist_req → func_ready=1 two cycles later.
- In BIST, errors @0x020, 0x020, 0x030 → entries 0 and 1 valid. BIST read @0x030 → mem_addr_a=0x1FD; bist_correct=1.
- Five distinct errors with DEPTH=4 → the fifth sets bist_repair_fail=1 and bist_correct=0; error @0x1F9 alone also sets the fail flag.
- Shift L cycles with sdi=0 after the two-entry case → sdo streams {0,000000000}×2, then {1,0x030},{1,0x020}. Shift the pattern back in → remap restored.
- Assert rst_n low mid-DRAIN → FSM in FUNC, CAM cleared, mem outputs follow functional inputs immediately.
